align_gearbox: RTL and testbench

Parametrised width converter that replaces the fixed align_s2p/align_p2s pair with one block. Mode is selected at elaboration from the parameters: pack (IDATA_BIT < ODATA_BIT), unpack (IDATA_BIT > ODATA_BIT) or register pass-through (equal widths). Adds valid/ready backpressure on both sides and last-word flush with lane count. Sits between the DMA/bus datapath and the compute core streams.

---
 rtl/align_gearbox.sv | 164 ++++++++++++++++
 tb/tb_align_gearbox.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/align_gearbox.sv
// Parametrised pack / unpack / pass-through width converter with valid/ready on both sides.
// Define ALIGN_GEARBOX_MSB_FIRST_EN to reverse lane order (first narrow word in the MSB lane).
module align_gearbox #(
    parameter int IDATA_BIT = 64,
    parameter int ODATA_BIT = 256,
    localparam int MAXW     = (IDATA_BIT > ODATA_BIT) ? IDATA_BIT : ODATA_BIT,
    localparam int MINW     = (IDATA_BIT > ODATA_BIT) ? ODATA_BIT : IDATA_BIT,
    localparam int RATIO    = MAXW / MINW,
    localparam int LANE_BIT = $clog2(RATIO) + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [IDATA_BIT-1:0] idata,
    input  logic                 idata_valid,
    input  logic                 idata_last,
    output logic                 idata_ready,
    output logic [ODATA_BIT-1:0] odata,
    output logic                 odata_valid,
    output logic                 odata_last,
    output logic [LANE_BIT-1:0]  odata_lanes,
    input  logic                 odata_ready
);

    localparam int CNT_W = (RATIO > 1) ? $clog2(RATIO) : 1;

`ifdef ALIGN_GEARBOX_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif

    if ((MAXW % MINW) != 0) begin : g_bad_ratio
        $error("align_gearbox: wide width must be an integer multiple of narrow width");
    end

    if (IDATA_BIT < ODATA_BIT) begin : g_pack
        logic [ODATA_BIT-1:0] r_pack;
        logic [ODATA_BIT-1:0] r_odata;
        logic [ODATA_BIT-1:0] w_assembled;
        logic [CNT_W-1:0]     r_cnt;
        logic [CNT_W-1:0]     w_lane;
        logic [LANE_BIT-1:0]  r_lanes;
        logic                 r_valid;
        logic                 r_last;
        logic                 w_ready;
        logic                 w_accept;
        logic                 w_done;

        assign w_ready  = !(r_valid && !odata_ready);
        assign w_accept = idata_valid && w_ready;
        assign w_done   = w_accept && ((r_cnt == CNT_W'(RATIO - 1)) || idata_last);
        assign w_lane   = MSB_FIRST ? (CNT_W'(RATIO - 1) - r_cnt) : r_cnt;

        // The completing lane is merged here so it lands in the output word on the same edge.
        always_comb begin
            w_assembled = r_pack;
            w_assembled[w_lane*IDATA_BIT +: IDATA_BIT] = idata;
        end

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_pack  <= '0;
                r_odata <= '0;
                r_cnt   <= '0;
                r_lanes <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (w_done) begin
                r_odata <= w_assembled;
                r_valid <= 1'b1;
                r_last  <= idata_last;
                r_lanes <= LANE_BIT'(r_cnt) + LANE_BIT'(1);
                r_cnt   <= '0;
                r_pack  <= '0;
            end else begin
                if (w_accept) begin
                    r_pack <= w_assembled;
                    r_cnt  <= r_cnt + CNT_W'(1);
                end
                if (odata_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end

        assign idata_ready = w_ready;
        assign odata       = r_odata;
        assign odata_valid = r_valid;
        assign odata_last  = r_last;
        assign odata_lanes = r_lanes;
    end else if (IDATA_BIT > ODATA_BIT) begin : g_unpack
        logic [IDATA_BIT-1:0] r_shift;
        logic [CNT_W-1:0]     r_cnt;
        logic [CNT_W-1:0]     w_lane;
        logic                 r_full;
        logic                 r_wlast;
        logic                 w_last_lane;
        logic                 w_ready;
        logic                 w_accept;

        assign w_last_lane = (r_cnt == CNT_W'(RATIO - 1));
        assign w_ready     = !r_full || (w_last_lane && odata_ready);
        assign w_accept    = idata_valid && w_ready;
        assign w_lane      = MSB_FIRST ? (CNT_W'(RATIO - 1) - r_cnt) : r_cnt;

        // A new word may load on the final lane's handshake, giving back-to-back words without a bubble.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_shift <= '0;
                r_cnt   <= '0;
                r_full  <= 1'b0;
                r_wlast <= 1'b0;
            end else if (w_accept) begin
                r_shift <= idata;
                r_cnt   <= '0;
                r_full  <= 1'b1;
                r_wlast <= idata_last;
            end else if (r_full && odata_ready) begin
                if (w_last_lane) begin
                    r_shift <= '0;
                    r_cnt   <= '0;
                    r_full  <= 1'b0;
                    r_wlast <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end

        assign idata_ready = w_ready;
        assign odata       = r_shift[w_lane*ODATA_BIT +: ODATA_BIT];
        assign odata_valid = r_full;
        assign odata_last  = r_full && r_wlast && w_last_lane;
        assign odata_lanes = LANE_BIT'(r_full);
    end else begin : g_pass
        logic [ODATA_BIT-1:0] r_odata;
        logic                 r_valid;
        logic                 r_last;
        logic                 w_ready;

        assign w_ready = !r_valid || odata_ready;

        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                r_odata <= '0;
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end else if (idata_valid && w_ready) begin
                r_odata <= idata;
                r_valid <= 1'b1;
                r_last  <= idata_last;
            end else if (odata_ready) begin
                r_valid <= 1'b0;
            end
        end

        assign idata_ready = w_ready;
        assign odata       = r_odata;
        assign odata_valid = r_valid;
        assign odata_last  = r_last;
        assign odata_lanes = LANE_BIT'(r_valid);
    end

endmodule

// File: tb/tb_align_gearbox.sv
// Directed bench for align_gearbox: pack 64->256, unpack 256->64 and pass-through 32->32 instances.
// Expected lane order follows ALIGN_GEARBOX_MSB_FIRST_EN when defined.
module tb_align_gearbox;

`ifdef ALIGN_GEARBOX_MSB_FIRST_EN
    localparam bit MSB = 1'b1;
`else
    localparam bit MSB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rstn;
    int   errors = 0;
    int   checks = 0;

    logic [63:0]  p_idata;
    logic         p_ivalid, p_ilast, p_iready, p_ovalid, p_olast, p_oready;
    logic [255:0] p_odata;
    logic [2:0]   p_olanes;

    logic [255:0] u_idata;
    logic         u_ivalid, u_ilast, u_iready, u_ovalid, u_olast, u_oready;
    logic [63:0]  u_odata;
    logic [2:0]   u_olanes;

    logic [31:0]  t_idata, t_odata;
    logic         t_ivalid, t_ilast, t_iready, t_ovalid, t_olast, t_oready;
    logic [0:0]   t_olanes;

    always #5 clk = ~clk;

    align_gearbox #(.IDATA_BIT(64), .ODATA_BIT(256)) u_pack (
        .clk(clk), .rstn(rstn), .idata(p_idata), .idata_valid(p_ivalid), .idata_last(p_ilast),
        .idata_ready(p_iready), .odata(p_odata), .odata_valid(p_ovalid), .odata_last(p_olast),
        .odata_lanes(p_olanes), .odata_ready(p_oready));

    align_gearbox #(.IDATA_BIT(256), .ODATA_BIT(64)) u_unpack (
        .clk(clk), .rstn(rstn), .idata(u_idata), .idata_valid(u_ivalid), .idata_last(u_ilast),
        .idata_ready(u_iready), .odata(u_odata), .odata_valid(u_ovalid), .odata_last(u_olast),
        .odata_lanes(u_olanes), .odata_ready(u_oready));

    align_gearbox #(.IDATA_BIT(32), .ODATA_BIT(32)) u_pass (
        .clk(clk), .rstn(rstn), .idata(t_idata), .idata_valid(t_ivalid), .idata_last(t_ilast),
        .idata_ready(t_iready), .odata(t_odata), .odata_valid(t_ovalid), .odata_last(t_olast),
        .odata_lanes(t_olanes), .odata_ready(t_oready));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        checks++; if (p_odata !== 256'd0) begin errors++; $display("[TB] FAIL rst_p_odata got=%h exp=0", p_odata); end
        checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_p_ovalid got=%b exp=0", p_ovalid); end
        checks++; if (p_olast !== 1'b0) begin errors++; $display("[TB] FAIL rst_p_olast got=%b exp=0", p_olast); end
        checks++; if (p_olanes !== 3'd0) begin errors++; $display("[TB] FAIL rst_p_olanes got=%0d exp=0", p_olanes); end
        checks++; if (p_iready !== 1'b1) begin errors++; $display("[TB] FAIL rst_p_iready got=%b exp=1", p_iready); end
        checks++; if (u_odata !== 64'd0) begin errors++; $display("[TB] FAIL rst_u_odata got=%h exp=0", u_odata); end
        checks++; if (u_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_u_ovalid got=%b exp=0", u_ovalid); end
        checks++; if (u_olanes !== 3'd0) begin errors++; $display("[TB] FAIL rst_u_olanes got=%0d exp=0", u_olanes); end
        checks++; if (u_iready !== 1'b1) begin errors++; $display("[TB] FAIL rst_u_iready got=%b exp=1", u_iready); end
        checks++; if (t_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_t_ovalid got=%b exp=0", t_ovalid); end
        checks++; if (t_iready !== 1'b1) begin errors++; $display("[TB] FAIL rst_t_iready got=%b exp=1", t_iready); end
    endtask

    task automatic test_pack;
        logic [63:0]  w [4];
        logic [255:0] exp;
        w[0] = 64'hAAAA_AAAA_AAAA_AAAA; w[1] = 64'hBBBB_BBBB_BBBB_BBBB;
        w[2] = 64'hCCCC_CCCC_CCCC_CCCC; w[3] = 64'hDDDD_DDDD_DDDD_DDDD;
        exp = MSB ? {w[0], w[1], w[2], w[3]} : {w[3], w[2], w[1], w[0]};
        p_ilast = 1'b0;
        for (int i = 0; i < 4; i++) begin
            p_ivalid = 1'b1;
            p_idata  = w[i];
            tick();
            if (i < 3) begin
                checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL pack_early_valid lane=%0d got=%b exp=0", i, p_ovalid); end
            end
        end
        p_ivalid = 1'b0;
        checks++; if (p_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL pack_valid got=%b exp=1", p_ovalid); end
        checks++; if (p_odata !== exp) begin errors++; $display("[TB] FAIL pack_data got=%h exp=%h", p_odata, exp); end
        checks++; if (p_olanes !== 3'd4) begin errors++; $display("[TB] FAIL pack_lanes got=%0d exp=4", p_olanes); end
        checks++; if (p_olast !== 1'b0) begin errors++; $display("[TB] FAIL pack_last got=%b exp=0", p_olast); end
        tick();
        checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL pack_single_valid got=%b exp=0", p_ovalid); end
    endtask

    task automatic test_pack_flush;
        logic [255:0] exp;
        logic [63:0]  w [4];
        p_ivalid = 1'b1;
        p_idata  = 64'hFFFF_FFFF_FFFF_FFFF;
        p_ilast  = 1'b1;
        tick();
        p_ivalid = 1'b0;
        p_ilast  = 1'b0;
        exp = MSB ? {64'hFFFF_FFFF_FFFF_FFFF, 192'd0} : {192'd0, 64'hFFFF_FFFF_FFFF_FFFF};
        checks++; if (p_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL flush_valid got=%b exp=1", p_ovalid); end
        checks++; if (p_odata !== exp) begin errors++; $display("[TB] FAIL flush_data got=%h exp=%h", p_odata, exp); end
        checks++; if (p_olanes !== 3'd1) begin errors++; $display("[TB] FAIL flush_lanes got=%0d exp=1", p_olanes); end
        checks++; if (p_olast !== 1'b1) begin errors++; $display("[TB] FAIL flush_last got=%b exp=1", p_olast); end
        tick();
        w[0] = 64'h1111_1111_1111_1111; w[1] = 64'h2222_2222_2222_2222;
        w[2] = 64'h3333_3333_3333_3333; w[3] = 64'h4444_4444_4444_4444;
        for (int i = 0; i < 4; i++) begin
            p_ivalid = 1'b1;
            p_idata  = w[i];
            p_ilast  = (i == 3);
            tick();
            if (i == 1) begin
                checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL flush_cnt_restart got=%b exp=0", p_ovalid); end
            end
        end
        p_ivalid = 1'b0;
        p_ilast  = 1'b0;
        exp = MSB ? {w[0], w[1], w[2], w[3]} : {w[3], w[2], w[1], w[0]};
        checks++; if (p_odata !== exp) begin errors++; $display("[TB] FAIL fullflush_data got=%h exp=%h", p_odata, exp); end
        checks++; if (p_olanes !== 3'd4) begin errors++; $display("[TB] FAIL fullflush_lanes got=%0d exp=4", p_olanes); end
        checks++; if (p_olast !== 1'b1) begin errors++; $display("[TB] FAIL fullflush_last got=%b exp=1", p_olast); end
        tick();
    endtask

    task automatic test_unpack;
        logic [63:0]  w2l [4];
        logic [63:0]  exp;
        w2l[0] = 64'h1111_1111_1111_1111; w2l[1] = 64'h2222_2222_2222_2222;
        w2l[2] = 64'h3333_3333_3333_3333; w2l[3] = 64'h4444_4444_4444_4444;
        u_oready = 1'b1;
        u_ivalid = 1'b1;
        u_idata  = {4{64'hAAAA_BBBB_CCCC_DDDD}};
        u_ilast  = 1'b1;
        tick();
        u_idata  = {w2l[3], w2l[2], w2l[1], w2l[0]};
        u_ilast  = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (u_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL unpack_valid lane=%0d got=%b exp=1", k, u_ovalid); end
            checks++; if (u_odata !== 64'hAAAA_BBBB_CCCC_DDDD) begin errors++; $display("[TB] FAIL unpack_data lane=%0d got=%h exp=aaaabbbbccccdddd", k, u_odata); end
            checks++; if (u_olast !== (k == 3)) begin errors++; $display("[TB] FAIL unpack_last lane=%0d got=%b exp=%b", k, u_olast, (k == 3)); end
            checks++; if (u_iready !== (k == 3)) begin errors++; $display("[TB] FAIL unpack_iready lane=%0d got=%b exp=%b", k, u_iready, (k == 3)); end
            checks++; if (u_olanes !== 3'd1) begin errors++; $display("[TB] FAIL unpack_lanes lane=%0d got=%0d exp=1", k, u_olanes); end
            tick();
        end
        u_ivalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp = MSB ? w2l[3-k] : w2l[k];
            checks++; if (u_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL b2b_valid lane=%0d got=%b exp=1", k, u_ovalid); end
            checks++; if (u_odata !== exp) begin errors++; $display("[TB] FAIL b2b_data lane=%0d got=%h exp=%h", k, u_odata, exp); end
            checks++; if (u_olast !== 1'b0) begin errors++; $display("[TB] FAIL b2b_last lane=%0d got=%b exp=0", k, u_olast); end
            tick();
        end
        checks++; if (u_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL unpack_drain got=%b exp=0", u_ovalid); end
    endtask

    task automatic test_backpressure_pack;
        logic [63:0]  pw [64];
        logic [255:0] exp, held;
        logic         stalled, in_hs, out_hs;
        int           in_i, out_n, cyc, ln;
        for (int i = 0; i < 64; i++) pw[i] = {$urandom(), $urandom()};
        in_i = 0; out_n = 0; cyc = 0; stalled = 1'b0; held = '0;
        p_ilast = 1'b0;
        while (out_n < 16 && cyc < 2000) begin
            p_oready = !((cyc % 16) >= 5 && (cyc % 16) <= 7);
            p_ivalid = (in_i < 64) && ((cyc % 11) != 3);
            p_idata  = (in_i < 64) ? pw[in_i] : 64'd0;
            #1;
            if (stalled) begin
                checks++; if (p_ovalid !== 1'b1 || p_odata !== held) begin errors++; $display("[TB] FAIL bp_pack_hold cyc=%0d got=%h exp=%h", cyc, p_odata, held); end
            end
            checks++; if (p_iready !== !(p_ovalid && !p_oready)) begin errors++; $display("[TB] FAIL bp_pack_iready cyc=%0d got=%b exp=%b", cyc, p_iready, !(p_ovalid && !p_oready)); end
            in_hs   = p_ivalid && p_iready;
            out_hs  = p_ovalid && p_oready;
            stalled = p_ovalid && !p_oready;
            held    = p_odata;
            if (out_hs) begin
                exp = '0;
                for (int j = 0; j < 4; j++) begin
                    ln = MSB ? 3 - j : j;
                    exp[ln*64 +: 64] = pw[out_n*4 + j];
                end
                checks++; if (p_odata !== exp) begin errors++; $display("[TB] FAIL bp_pack_data n=%0d got=%h exp=%h", out_n, p_odata, exp); end
                checks++; if (p_olanes !== 3'd4) begin errors++; $display("[TB] FAIL bp_pack_lanes n=%0d got=%0d exp=4", out_n, p_olanes); end
                out_n++;
            end
            tick();
            if (in_hs) in_i++;
            cyc++;
        end
        p_ivalid = 1'b0;
        p_oready = 1'b1;
        checks++; if (out_n != 16) begin errors++; $display("[TB] FAIL bp_pack_count got=%0d exp=16", out_n); end
        tick();
        checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_pack_extra got=%b exp=0", p_ovalid); end
    endtask

    task automatic test_backpressure_unpack;
        logic [255:0] uw [16];
        logic [63:0]  exp, held;
        logic         stalled, in_hs, out_hs, exp_rdy;
        int           in_i, out_n, cyc, ln;
        for (int i = 0; i < 16; i++) uw[i] = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        in_i = 0; out_n = 0; cyc = 0; stalled = 1'b0; held = '0;
        while (out_n < 64 && cyc < 2000) begin
            u_oready = !((cyc % 16) >= 9 && (cyc % 16) <= 11);
            u_ivalid = (in_i < 16) && ((cyc % 7) != 2);
            u_idata  = (in_i < 16) ? uw[in_i] : 256'd0;
            u_ilast  = (in_i == 15);
            #1;
            if (stalled) begin
                checks++; if (u_ovalid !== 1'b1 || u_odata !== held) begin errors++; $display("[TB] FAIL bp_unpack_hold cyc=%0d got=%h exp=%h", cyc, u_odata, held); end
            end
            exp_rdy = !u_ovalid || ((out_n % 4) == 3 && u_oready);
            checks++; if (u_iready !== exp_rdy) begin errors++; $display("[TB] FAIL bp_unpack_iready cyc=%0d got=%b exp=%b", cyc, u_iready, exp_rdy); end
            in_hs   = u_ivalid && u_iready;
            out_hs  = u_ovalid && u_oready;
            stalled = u_ovalid && !u_oready;
            held    = u_odata;
            if (out_hs) begin
                ln  = MSB ? 3 - (out_n % 4) : (out_n % 4);
                exp = uw[out_n/4][ln*64 +: 64];
                checks++; if (u_odata !== exp) begin errors++; $display("[TB] FAIL bp_unpack_data n=%0d got=%h exp=%h", out_n, u_odata, exp); end
                checks++; if (u_olast !== (out_n == 63)) begin errors++; $display("[TB] FAIL bp_unpack_last n=%0d got=%b exp=%b", out_n, u_olast, (out_n == 63)); end
                out_n++;
            end
            tick();
            if (in_hs) in_i++;
            cyc++;
        end
        u_ivalid = 1'b0;
        u_ilast  = 1'b0;
        u_oready = 1'b1;
        checks++; if (out_n != 64) begin errors++; $display("[TB] FAIL bp_unpack_count got=%0d exp=64", out_n); end
        tick();
        checks++; if (u_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_unpack_extra got=%b exp=0", u_ovalid); end
    endtask

    task automatic test_passthrough;
        t_oready = 1'b1;
        t_ivalid = 1'b1;
        t_idata  = 32'h1234_5678;
        t_ilast  = 1'b1;
        tick();
        t_oready = 1'b0;
        t_idata  = 32'hCAFE_F00D;
        t_ilast  = 1'b0;
        #1;
        checks++; if (t_ovalid !== 1'b1) begin errors++; $display("[TB] FAIL pass_valid got=%b exp=1", t_ovalid); end
        checks++; if (t_odata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL pass_data got=%h exp=12345678", t_odata); end
        checks++; if (t_olast !== 1'b1) begin errors++; $display("[TB] FAIL pass_last got=%b exp=1", t_olast); end
        checks++; if (t_olanes !== 1'b1) begin errors++; $display("[TB] FAIL pass_lanes got=%0d exp=1", t_olanes); end
        checks++; if (t_iready !== 1'b0) begin errors++; $display("[TB] FAIL pass_stall_ready got=%b exp=0", t_iready); end
        tick();
        checks++; if (t_odata !== 32'h1234_5678) begin errors++; $display("[TB] FAIL pass_hold got=%h exp=12345678", t_odata); end
        t_oready = 1'b1;
        #1;
        checks++; if (t_iready !== 1'b1) begin errors++; $display("[TB] FAIL pass_ready got=%b exp=1", t_iready); end
        tick();
        t_ivalid = 1'b0;
        checks++; if (t_odata !== 32'hCAFE_F00D) begin errors++; $display("[TB] FAIL pass_data2 got=%h exp=cafef00d", t_odata); end
        checks++; if (t_olast !== 1'b0) begin errors++; $display("[TB] FAIL pass_last2 got=%b exp=0", t_olast); end
        tick();
        checks++; if (t_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL pass_drain got=%b exp=0", t_ovalid); end
    endtask

    task automatic test_reset_mid;
        logic [63:0]  w [4];
        logic [255:0] exp;
        p_oready = 1'b1;
        p_ilast  = 1'b0;
        p_ivalid = 1'b1;
        p_idata  = 64'h0A0A_0A0A_0A0A_0A0A;
        tick();
        p_idata  = 64'h0B0B_0B0B_0B0B_0B0B;
        tick();
        p_ivalid = 1'b0;
        rstn     = 1'b0;
        #1;
        checks++; if (p_odata !== 256'd0) begin errors++; $display("[TB] FAIL midrst_odata got=%h exp=0", p_odata); end
        checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_ovalid got=%b exp=0", p_ovalid); end
        checks++; if (p_olanes !== 3'd0) begin errors++; $display("[TB] FAIL midrst_lanes got=%0d exp=0", p_olanes); end
        checks++; if (p_iready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_iready got=%b exp=1", p_iready); end
        tick();
        rstn = 1'b1;
        w[0] = 64'h0C0C_0C0C_0C0C_0C0C; w[1] = 64'h0D0D_0D0D_0D0D_0D0D;
        w[2] = 64'h0E0E_0E0E_0E0E_0E0E; w[3] = 64'h0F0F_0F0F_0F0F_0F0F;
        for (int i = 0; i < 4; i++) begin
            p_ivalid = 1'b1;
            p_idata  = w[i];
            tick();
            if (i == 1) begin
                checks++; if (p_ovalid !== 1'b0) begin errors++; $display("[TB] FAIL midrst_stale got=%b exp=0", p_ovalid); end
            end
        end
        p_ivalid = 1'b0;
        exp = MSB ? {w[0], w[1], w[2], w[3]} : {w[3], w[2], w[1], w[0]};
        checks++; if (p_odata !== exp) begin errors++; $display("[TB] FAIL midrst_data got=%h exp=%h", p_odata, exp); end
        checks++; if (p_olanes !== 3'd4) begin errors++; $display("[TB] FAIL midrst_new_lanes got=%0d exp=4", p_olanes); end
        tick();
    endtask

    initial begin
        rstn = 1'b0;
        p_idata = '0; p_ivalid = 1'b0; p_ilast = 1'b0; p_oready = 1'b1;
        u_idata = '0; u_ivalid = 1'b0; u_ilast = 1'b0; u_oready = 1'b1;
        t_idata = '0; t_ivalid = 1'b0; t_ilast = 1'b0; t_oready = 1'b1;
        #2;
        test_reset();
        tick();
        rstn = 1'b1;
        tick();
        test_pack();
        test_pack_flush();
        test_unpack();
        test_backpressure_pack();
        test_backpressure_unpack();
        test_passthrough();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
